// File: rtl/marker_event_tracker_if.sv
// rtl/marker_event_tracker_if.sv - marker event stream between the tracker and its consumer
// Ports:
//   evt_valid  head record present
//   evt_ready  consumer accepts the head this cycle
//   evt_data   {is_commit, id[3:0], timestamp[CW-1:0]}
interface marker_event_tracker_if #(
    parameter int CW = 32
);
    logic          evt_valid;
    logic          evt_ready;
    logic [4+CW:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/marker_event_tracker.sv
// rtl/marker_event_tracker.sv - marker NOP timestamping, event FIFO and phase window tracking
// Ports:
//   clock, reset            clock; asynchronous active-low reset
//   enq_valid/enq_inst      ROB enqueue slot 0 probe
//   commit_valid/commit_inst ROB commit slot 0 probe
//   taint_base/variant      taint sums of the two SoCs
//   evt                     event stream (master side)
//   phase_active            one bit per phase, 1 while STARTED
//   phase_sel               selects phase for sel_cycles/sel_taint_max
//   overflow_cnt            saturating count of dropped records
//   protocol_err            sticky marker ordering error
module marker_event_tracker #(
    parameter int CW    = 32,
    parameter int TW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_inst,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_inst,
    input  logic [TW-1:0]            taint_base,
    input  logic [TW-1:0]            taint_variant,
    marker_event_tracker_if.master   evt,
    output logic [5:0]               phase_active,
    input  logic [2:0]               phase_sel,
    output logic [CW-1:0]            sel_cycles,
    output logic [TW-1:0]            sel_taint_max,
    output logic [15:0]              overflow_cnt,
    output logic                     protocol_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 5 + CW;

    typedef enum logic [1:0] {IDLE, STARTED, CLOSED} phase_state_t;

    function automatic logic is_marker(input logic [31:0] inst);
        return (inst[31:24] == 8'h00) && (inst[19:0] == 20'h02013) && (inst[23:20] <= 4'd11);
    endfunction

    logic [CW-1:0] cnt_q;
    logic          enq_m, com_m;
    logic [3:0]    com_id;
    logic [5:0]    hit_start, hit_end;
    logic [TW-1:0] diff;

    always_comb begin
        enq_m  = enq_valid && is_marker(enq_inst);
        com_m  = commit_valid && is_marker(commit_inst);
        com_id = commit_inst[23:20];
        diff   = (taint_base >= taint_variant) ? taint_base - taint_variant
                                               : taint_variant - taint_base;
        for (int p = 0; p < 6; p++) begin
            hit_start[p] = com_m && (com_id[3:1] == 3'(p)) && !com_id[0];
            hit_end[p]   = com_m && (com_id[3:1] == 3'(p)) && com_id[0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_q + 1'b1;
    end

    // Event FIFO: up to two writes (enq record first) and one read per cycle.
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, free;
    logic          pop;
    logic [1:0]    n_wr, n_drop;
    logic [RW-1:0] wr0_data, wr1_data;
    logic [16:0]   ovf_sum;

    always_comb begin
        pop      = (count_q != '0) && evt.evt_ready;
        // Space freed by this cycle's pop is usable by this cycle's pushes.
        free     = (AW+1)'(DEPTH) - count_q + {{AW{1'b0}}, pop};
        n_wr     = 2'd0;
        n_drop   = 2'd0;
        wr0_data = enq_m ? {1'b0, enq_inst[23:20], cnt_q} : {1'b1, com_id, cnt_q};
        wr1_data = {1'b1, com_id, cnt_q};
        if (enq_m && com_m) begin
            if (free >= (AW+1)'(2)) begin
                n_wr = 2'd2;
            end else if (free == (AW+1)'(1)) begin
                n_wr   = 2'd1;
                n_drop = 2'd1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (enq_m || com_m) begin
            if (free != '0) n_wr = 2'd1;
            else            n_drop = 2'd1;
        end
        ovf_sum = {1'b0, overflow_cnt} + {15'd0, n_drop};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            overflow_cnt <= '0;
        end else begin
            if (n_wr != 2'd0) mem[wr_ptr] <= wr0_data;
            if (n_wr == 2'd2) mem[wr_ptr + AW'(1)] <= wr1_data;
            wr_ptr       <= wr_ptr + AW'(n_wr);
            rd_ptr       <= rd_ptr + AW'(pop);
            count_q      <= count_q + (AW+1)'(n_wr) - (AW+1)'(pop);
            overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_data  = (count_q != '0) ? mem[rd_ptr] : '0;

    // Phase FSMs, driven only by commit markers.
    phase_state_t  state_q   [6];
    phase_state_t  state_nxt [6];
    logic          err_set;
    logic [CW-1:0] cyc_q  [6];
    logic [TW-1:0] tmax_q [6];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 6; p++) state_q[p] <= IDLE;
        end else begin
            for (int p = 0; p < 6; p++) state_q[p] <= state_nxt[p];
        end
    end

    always_comb begin
        err_set = 1'b0;
        for (int p = 0; p < 6; p++) begin
            state_nxt[p] = state_q[p];
            case (state_q[p])
                STARTED: begin
                    if (hit_start[p])    err_set = 1'b1;
                    else if (hit_end[p]) state_nxt[p] = CLOSED;
                end
                default: begin
                    if (hit_start[p])    state_nxt[p] = STARTED;
                    else if (hit_end[p]) err_set = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        for (int p = 0; p < 6; p++) phase_active[p] = (state_q[p] == STARTED);
    end

    // Start cycle loads the current diff rather than clearing; the end-commit
    // cycle is still STARTED so its diff and tick are included before freezing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            protocol_err <= 1'b0;
            for (int p = 0; p < 6; p++) begin
                cyc_q[p]  <= '0;
                tmax_q[p] <= '0;
            end
        end else begin
            protocol_err <= protocol_err | err_set;
            for (int p = 0; p < 6; p++) begin
                if (hit_start[p]) begin
                    cyc_q[p]  <= '0;
                    tmax_q[p] <= diff;
                end else if (state_q[p] == STARTED) begin
                    if (cyc_q[p] != '1) cyc_q[p] <= cyc_q[p] + 1'b1;
                    if (diff > tmax_q[p]) tmax_q[p] <= diff;
                end
            end
        end
    end

    always_comb begin
        sel_cycles    = '0;
        sel_taint_max = '0;
        for (int p = 0; p < 6; p++) begin
            if (phase_sel == 3'(p)) begin
                sel_cycles    = cyc_q[p];
                sel_taint_max = tmax_q[p];
            end
        end
    end
endmodule

// File: tb/tb_marker_event_tracker.sv
// tb/tb_marker_event_tracker.sv - scoreboard bench for marker_event_tracker
module tb_marker_event_tracker;
    localparam int CW    = 32;
    localparam int TW    = 32;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enq_valid = 1'b0;
    logic [31:0]   enq_inst = '0;
    logic          commit_valid = 1'b0;
    logic [31:0]   commit_inst = '0;
    logic [TW-1:0] taint_base = '0;
    logic [TW-1:0] taint_variant = '0;
    logic [5:0]    phase_active;
    logic [2:0]    phase_sel = 3'd0;
    logic [CW-1:0] sel_cycles;
    logic [TW-1:0] sel_taint_max;
    logic [15:0]   overflow_cnt;
    logic          protocol_err;

    marker_event_tracker_if #(.CW(CW)) evt ();

    marker_event_tracker #(.CW(CW), .TW(TW), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .enq_valid     (enq_valid),
        .enq_inst      (enq_inst),
        .commit_valid  (commit_valid),
        .commit_inst   (commit_inst),
        .taint_base    (taint_base),
        .taint_variant (taint_variant),
        .evt           (evt),
        .phase_active  (phase_active),
        .phase_sel     (phase_sel),
        .sel_cycles    (sel_cycles),
        .sel_taint_max (sel_taint_max),
        .overflow_cnt  (overflow_cnt),
        .protocol_err  (protocol_err)
    );

    always #5 clock = ~clock;

    int n_run  = 0;
    int n_fail = 0;
    int tb_cnt = 0;
    logic [4+CW:0] exp_q [$];

    always @(posedge clock or negedge reset) begin
        if (!reset) tb_cnt <= 0;
        else        tb_cnt <= tb_cnt + 1;
    end

    function automatic logic [4+CW:0] rec(input logic c, input int id, input int ts);
        logic [3:0]    id4 = 4'(id);
        logic [CW-1:0] t   = CW'(ts);
        return {c, id4, t};
    endfunction

    function automatic logic [31:0] mk(input int id);
        return 32'h00002013 | (32'(id) << 20);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [31:0] ei, input logic cv, input logic [31:0] ci);
        enq_valid    = ev;
        enq_inst     = ei;
        commit_valid = cv;
        commit_inst  = ci;
        @(negedge clock);
        enq_valid    = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int guard = 0;
        while (tb_cnt != target && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        if (tb_cnt != target) begin
            n_run++;
            n_fail++;
            $display("FAIL wait_cnt: counter %0d never reached %0d", tb_cnt, target);
        end
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted head is compared against the scoreboard front.
    initial begin
        logic [4+CW:0] e;
        forever begin
            @(negedge clock);
            #3;
            if (reset && evt.evt_valid && evt.evt_ready) begin
                n_run++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL evt_pop: unexpected record %0h, expected none", evt.evt_data);
                end else begin
                    e = exp_q.pop_front();
                    if (evt.evt_data !== e) begin
                        n_fail++;
                        $display("FAIL evt_pop: got %0h expected %0h", evt.evt_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        evt.evt_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_evt_valid", 64'(evt.evt_valid), 64'd0);
        check("rst_evt_data", 64'(evt.evt_data), 64'd0);
        check("rst_phase_active", 64'(phase_active), 64'd0);
        check("rst_overflow", 64'(overflow_cnt), 64'd0);
        check("rst_protocol_err", 64'(protocol_err), 64'd0);
        check("rst_sel_cycles", 64'(sel_cycles), 64'd0);
        reset = 1'b1;

        // Basic window on VCTM.
        wait_cnt(10);
        exp_q.push_back(rec(1'b1, 0, 10));
        drive(1'b0, '0, 1'b1, 32'h00002013);
        wait_cnt(20);
        check("vctm_active_mid", 64'(phase_active[0]), 64'd1);
        wait_cnt(25);
        exp_q.push_back(rec(1'b1, 1, 25));
        drive(1'b0, '0, 1'b1, 32'h00102013);
        check("vctm_cycles", 64'(sel_cycles), 64'd15);
        check("vctm_active_after", 64'(phase_active[0]), 64'd0);
        check("vctm_taint", 64'(sel_taint_max), 64'd0);

        // Same-cycle enq and commit markers.
        wait_cnt(40);
        exp_q.push_back(rec(1'b0, 4, 40));
        exp_q.push_back(rec(1'b1, 10, 40));
        drive(1'b1, 32'h00402013, 1'b1, 32'h00a02013);
        check("bim_active", 64'(phase_active[5]), 64'd1);
        check("texe_not_active", 64'(phase_active[2]), 64'd0);

        // Taint peak in LEAK.
        wait_cnt(50);
        phase_sel = 3'd3;
        exp_q.push_back(rec(1'b1, 6, 50));
        drive(1'b0, '0, 1'b1, 32'h00602013);
        taint_base = 5;   taint_variant = 9; @(negedge clock);
        taint_base = 100; taint_variant = 3; @(negedge clock);
        taint_base = 7;   taint_variant = 7; @(negedge clock);
        taint_base = 1;   taint_variant = 2;
        exp_q.push_back(rec(1'b1, 7, 54));
        drive(1'b0, '0, 1'b1, 32'h00702013);
        check("leak_taint_max", 64'(sel_taint_max), 64'd97);
        check("leak_cycles", 64'(sel_cycles), 64'd4);
        taint_base = 1000; taint_variant = 0;
        repeat (2) @(negedge clock);
        check("leak_taint_frozen", 64'(sel_taint_max), 64'd97);
        phase_sel = 3'd6;
        #1;
        check("sel6_cycles", 64'(sel_cycles), 64'd0);
        check("sel6_taint", 64'(sel_taint_max), 64'd0);
        phase_sel = 3'd3;

        // Reopen LEAK: start diff loads, end diff included, old peak cleared.
        wait_cnt(60);
        taint_base = 0; taint_variant = 50;
        exp_q.push_back(rec(1'b1, 6, 60));
        drive(1'b0, '0, 1'b1, 32'h00602013);
        taint_base = 0; taint_variant = 0; @(negedge clock);
        taint_base = 60; taint_variant = 0;
        exp_q.push_back(rec(1'b1, 7, 62));
        drive(1'b0, '0, 1'b1, 32'h00702013);
        taint_base = 0;
        check("leak2_taint_max", 64'(sel_taint_max), 64'd60);
        check("leak2_cycles", 64'(sel_cycles), 64'd2);

        // Non-markers and a protocol error.
        wait_cnt(66);
        drive(1'b1, 32'h00002093, 1'b1, 32'h00c02013);
        drive(1'b0, '0, 1'b1, 32'h00002093);
        check("nonmarker_err", 64'(protocol_err), 64'd0);
        check("nonmarker_phases", 64'(phase_active), 64'h20);
        wait_cnt(70);
        exp_q.push_back(rec(1'b1, 3, 70));
        drive(1'b0, '0, 1'b1, 32'h00302013);
        check("delay_end_err", 64'(protocol_err), 64'd1);
        check("delay_stays_idle", 64'(phase_active[1]), 64'd0);

        // Overflow with the consumer stalled.
        wait_cnt(80);
        evt.evt_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) exp_q.push_back(rec(1'b0, i % 12, 80 + i));
            drive(1'b1, mk(i % 12), 1'b0, '0);
        end
        check("ovf_cnt3", 64'(overflow_cnt), 64'd3);
        wait_cnt(100);
        evt.evt_ready = 1'b1;
        exp_q.push_back(rec(1'b0, 11, 100));
        drive(1'b1, mk(11), 1'b1, mk(8));
        evt.evt_ready = 1'b0;
        check("ovf_cnt4", 64'(overflow_cnt), 64'd4);
        check("init_started_on_drop", 64'(phase_active[4]), 64'd1);
        evt.evt_ready = 1'b1;
        drain("ovf_drain");
        @(negedge clock);
        check("ovf_empty", 64'(evt.evt_valid), 64'd0);

        // Asynchronous reset mid-window.
        evt.evt_ready = 1'b0;
        drive(1'b0, '0, 1'b1, mk(2));
        check("pre_rst_delay_active", 64'(phase_active[1]), 64'd1);
        check("pre_rst_evt_valid", 64'(evt.evt_valid), 64'd1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("arst_evt_valid", 64'(evt.evt_valid), 64'd0);
        check("arst_evt_data", 64'(evt.evt_data), 64'd0);
        check("arst_phase_active", 64'(phase_active), 64'd0);
        check("arst_protocol_err", 64'(protocol_err), 64'd0);
        check("arst_overflow", 64'(overflow_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        evt.evt_ready = 1'b1;
        exp_q.push_back(rec(1'b1, 4, 0));
        drive(1'b0, '0, 1'b1, mk(4));
        drain("post_rst_drain");
        check("post_rst_phases", 64'(phase_active), 64'h04);

        @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/marker_event_tracker.md
Name: marker_event_tracker

Overview:
- Sits between the BOOM ROB probe points and the testbench logging/DPI layer.
- Watches ROB enqueue and commit slot 0 for marker NOPs of the form addi x0,x0,N, encoded 0x00N02013 with N = 0..11.
- Timestamps each marker and buffers it in an event FIFO for a consumer to drain.
- Tracks six phase windows (VCTM, DELAY, TEXE, LEAK, INIT, BIM) and, inside each window, the duration and the peak base/variant taint divergence.

Parameters:
- CW, 32: width of the free-running cycle counter and all timestamps.
- TW, 32: width of the taint_sum inputs.
- DEPTH, 16: event FIFO depth. Must be a power of two and at least 2.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; state is cleared while reset==0.
- enq_valid  in  1  ROB enqueue slot 0 valid.
- enq_inst  in  32  ROB enqueue slot 0 debug_inst.
- commit_valid  in  1  ROB commit slot 0 valid.
- commit_inst  in  32  ROB commit slot 0 debug_inst.
- taint_base  in  TW  base SoC taint_sum.
- taint_variant  in  TW  variant SoC taint_sum.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts the head.
- evt_data  out  5+CW  head record: {is_commit[1], id[3:0], timestamp[CW-1:0]}.
- phase_active  out  6  bit p is 1 while phase p is STARTED.
- phase_sel  in  3  phase selector, values 0..5.
- sel_cycles  out  CW  duration counter of the selected phase.
- sel_taint_max  out  TW  peak |base-variant| inside the selected phase.
- overflow_cnt  out  16  number of records dropped because the FIFO was full; saturates.
- protocol_err  out  1  sticky marker-ordering error.

Behaviour:
- Reset: every output and internal register is 0, including FIFO pointers, FSMs and the counter. evt_data is 0 while the FIFO is empty.
- Cycle counter: increments by 1 on each posedge after reset deassertion and wraps modulo 2^CW. A marker's timestamp is the counter value in the cycle the marker is sampled.
- Marker decode: an instruction is a marker when inst[31:24]==0, inst[19:0]==20'h02013 and inst[23:20] <= 11. id = inst[23:20]. Phase p = id>>1; an even id is a start, an odd id is an end. Ids 12..15 are not markers.
- Event push:
  - An enq marker pushes {0,id,ts}; a commit marker pushes {1,id,ts}.
  - Both may push in the same cycle; the enq record is ordered before the commit record.
  - The FIFO supports 2 writes plus 1 read per cycle.
  - Free space is computed after the same-cycle pop.
  - If space is 1 and two records arrive, the enq record is stored and the commit record is dropped.
  - Each dropped record adds 1 to overflow_cnt, saturating at 16'hFFFF.
- Event pop: a pop happens when evt_valid && evt_ready. The registered head updates next cycle.
  - A record written into an empty FIFO raises evt_valid one cycle later (latency 1).
  - Pushing into an empty FIFO at the same time as a pop is legal; no bypass.
- Phase FSM, one per phase, states IDLE, STARTED, CLOSED. Only commit markers drive it; enq markers affect only the FIFO.
  - Start commit in IDLE or CLOSED: go to STARTED, set cycles=0 and taint_max=0.
  - Start commit in STARTED: restart with cycles=0 and taint_max=0, and set protocol_err.
  - End commit in STARTED: go to CLOSED; cycles and taint_max freeze.
  - End commit in IDLE or CLOSED: state is unchanged and protocol_err is set.
- While STARTED:
  - cycles increments by 1 each cycle, saturating at all-ones. The cycle of the start commit counts as cycle 0.
  - diff = |taint_base - taint_variant|, computed as an unsigned TW-bit magnitude.
  - taint_max takes max(taint_max, diff) each cycle, including the start cycle: diff is sampled in the start cycle and loads taint_max, taking priority over the clear.
  - On the end-commit cycle, the final diff is included before the freeze.
- phase_active[p] = (state_p == STARTED).
- sel_cycles and sel_taint_max are combinational muxes on phase_sel. Values 6 and 7 select 0.
- protocol_err is cleared only by reset.
- Reset asserted mid-operation: FIFO contents, all FSMs and all counters clear immediately (asynchronous).

Test Plan:
- Basic window: commit 0x00002013 at counter 10, then commit 0x00102013 at counter 25.
  - Required: FIFO holds {1,0,10} and {1,1,25}.
  - With phase_sel=0: sel_cycles=15 and phase_active[0]=0 afterwards.
- Same-cycle enq and commit: enq 0x00402013 and commit 0x00a02013 at ts 40.
  - Required: pops in order {0,4,40} then {1,10,40}.
  - phase_active[5]=1 and phase_active[2]=0.
- Taint peak: open LEAK (id 6); drive base/variant pairs 5/9, 100/3, 7/7, then commit id 7.
  - Required: sel_taint_max=97 with phase_sel=3, frozen after the close.
- Overflow: hold evt_ready=0 and push DEPTH+3 markers.
  - Required: exactly DEPTH records retained in order, overflow_cnt=3.
  - Then a 1-space plus dual push stores only the enq record and overflow_cnt becomes 4.
- Protocol errors and non-markers:
  - Commit 0x00302013 with DELAY IDLE: protocol_err=1, state stays IDLE.
  - 0x00c02013 and 0x00002093: no push, no error change.
- Async reset mid-window: assert reset=0 between clock edges with the FIFO non-empty and phase 1 STARTED.
  - Required: evt_valid=0, phase_active=0, counter=0 with no clock edge.
